// File: rtl/pa_risc_wb_trace_buffer.sv
// Circular trace buffer for PA-RISC register-file writebacks: captures {pc, reg, data}
// with watch masking, wrap / stop-when-full / pre-post-trigger sessions and stream readout.
module pa_risc_wb_trace_buffer #(
    parameter int                      DATA_W     = 32,
    parameter int                      PC_W       = 32,
    parameter int                      REG_AW     = 5,
    parameter int                      DEPTH      = 16,
    parameter logic [(2**REG_AW)-1:0]  WATCH_MASK = 32'hFFFF_FFFE,
    localparam int                     ENTRY_W    = PC_W + REG_AW + DATA_W,
    localparam int                     CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               arm_i,
    input  logic [1:0]         mode_i,
    input  logic [PC_W-1:0]    trig_pc_i,
    input  logic [CNT_W-1:0]   post_cnt_i,
    input  logic               stop_i,
    input  logic               wb_valid_i,
    input  logic [REG_AW-1:0]  wb_reg_i,
    input  logic [DATA_W-1:0]  wb_data_i,
    input  logic [PC_W-1:0]    wb_pc_i,
    input  logic               rd_ready_i,
    output logic               rd_valid_o,
    output logic [ENTRY_W-1:0] rd_data_o,
    output logic [CNT_W-1:0]   count_o,
    output logic [1:0]         state_o,
    output logic               overflow_o
);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [1:0] MODE_WRAP  = 2'd0;
    localparam logic [1:0] MODE_STOP  = 2'd1;
    localparam logic [1:0] MODE_TRIG  = 2'd2;

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic [1:0]         state_q,    state_d;
    logic [1:0]         mode_q,     mode_d;
    logic [CNT_W-1:0]   post_cfg_q, post_cfg_d;
    logic [CNT_W-1:0]   post_q,     post_d;
    logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0]   count_q,    count_d;
    logic               ovf_q,      ovf_d;
    logic               rd_valid_q, rd_valid_d;
    logic [ENTRY_W-1:0] rd_data_q,  rd_data_d;

    logic               event_s;
    logic               capturing_s;
    logic               full_s;
    logic               pop_s;
    logic               push_s;
    logic               overwrite_s;
    logic               arm_ok_s;
    logic [ENTRY_W-1:0] wentry_s;

    assign event_s     = wb_valid_i && (wb_reg_i != '0) && WATCH_MASK[wb_reg_i];
    assign capturing_s = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
    assign full_s      = (count_q == CNT_W'(DEPTH));
    assign pop_s       = (count_q != '0) && rd_ready_i;
    assign push_s      = capturing_s && event_s && !((mode_q == MODE_STOP) && full_s);
    assign overwrite_s = push_s && full_s && !pop_s;
    assign arm_ok_s    = arm_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign wentry_s    = {wb_pc_i, wb_reg_i, wb_data_i};

    // Next-state computation for pointers, occupancy, session FSM and the registered head.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        post_cfg_d = post_cfg_q;
        post_d     = post_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;

        if (pop_s || overwrite_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        // Overwrite-when-full keeps the count; a simultaneous pop makes room instead.
        if (push_s && !pop_s && !full_s) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_s && !push_s) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
        if (overwrite_s && (mode_q == MODE_WRAP)) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm_ok_s) begin
                    mode_d     = (mode_i == 2'd3) ? MODE_WRAP : mode_i;
                    post_cfg_d = post_cnt_i;
                    state_d    = (mode_i == MODE_TRIG) ? ST_ARMED : ST_CAPTURE;
                    if (state_q == ST_DONE) begin
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                        count_d  = '0;
                        ovf_d    = 1'b0;
                    end else begin
                        ovf_d    = ovf_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_ARMED: begin
                if (stop_i) begin
                    state_d = ST_DONE;
                end else if (push_s && (wb_pc_i == trig_pc_i)) begin
                    post_d  = post_cfg_q;
                    state_d = (post_cfg_q == '0) ? ST_DONE : ST_CAPTURE;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_CAPTURE: begin
                if (stop_i) begin
                    state_d = ST_DONE;
                end else if (push_s) begin
                    case (mode_q)
                        MODE_TRIG: begin
                            post_d = post_q - CNT_W'(1);
                            if (post_q == CNT_W'(1)) begin
                                state_d = ST_DONE;
                            end else begin
                                state_d = ST_CAPTURE;
                            end
                        end
                        MODE_STOP: begin
                            if (count_d == CNT_W'(DEPTH)) begin
                                state_d = ST_DONE;
                            end else begin
                                state_d = ST_CAPTURE;
                            end
                        end
                        default: state_d = ST_CAPTURE;
                    endcase
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A write landing on the next head slot is forwarded, since mem_q updates at the same edge.
        rd_valid_d = (count_d != '0);
        if (count_d == '0) begin
            rd_data_d = '0;
        end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
            rd_data_d = wentry_s;
        end else begin
            rd_data_d = mem_q[rd_ptr_d];
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_WRAP;
            post_cfg_q <= '0;
            post_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            post_cfg_q <= post_cfg_d;
            post_q     <= post_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Entry storage; contents are only observable through rd_data_q, which is zero when empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wentry_s;
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
    assign count_o    = count_q;
    assign state_o    = state_q;
    assign overflow_o = ovf_q;
endmodule

// File: tb/tb_pa_risc_wb_trace_buffer.sv
// Directed plus randomized bench for pa_risc_wb_trace_buffer, checked against a queue-based
// reference model of the capture sessions.
module tb_pa_risc_wb_trace_buffer;
    localparam int DATA_W  = 32;
    localparam int PC_W    = 32;
    localparam int REG_AW  = 5;
    localparam int DEPTH   = 16;
    localparam int ENTRY_W = PC_W + REG_AW + DATA_W;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    // GR15 is masked out in addition to GR0 so masking is exercised.
    localparam logic [31:0] MASK = 32'hFFFF_7FFE;

    logic               clk;
    logic               reset_n;
    logic               arm;
    logic [1:0]         mode;
    logic [PC_W-1:0]    trig_pc;
    logic [CNT_W-1:0]   post_cnt;
    logic               stop;
    logic               wb_valid;
    logic [REG_AW-1:0]  wb_reg;
    logic [DATA_W-1:0]  wb_data;
    logic [PC_W-1:0]    wb_pc;
    logic               rd_ready;
    logic               rd_valid;
    logic [ENTRY_W-1:0] rd_data;
    logic [CNT_W-1:0]   count;
    logic [1:0]         state;
    logic               overflow;

    pa_risc_wb_trace_buffer #(
        .DATA_W(DATA_W), .PC_W(PC_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .WATCH_MASK(MASK)
    ) dut (
        .clk(clk), .reset(reset_n), .arm_i(arm), .mode_i(mode), .trig_pc_i(trig_pc),
        .post_cnt_i(post_cnt), .stop_i(stop), .wb_valid_i(wb_valid), .wb_reg_i(wb_reg),
        .wb_data_i(wb_data), .wb_pc_i(wb_pc), .rd_ready_i(rd_ready), .rd_valid_o(rd_valid),
        .rd_data_o(rd_data), .count_o(count), .state_o(state), .overflow_o(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [ENTRY_W-1:0] mq[$];
    int m_state, m_mode, m_post_cfg, m_post;
    bit m_ovf;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [ENTRY_W-1:0] obs, input logic [ENTRY_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_state = 0; m_mode = 0; m_post_cfg = 0; m_post = 0; m_ovf = 1'b0;
    endtask

    task automatic model_start();
        m_mode     = (mode == 2'd3) ? 0 : int'(mode);
        m_post_cfg = int'(post_cnt);
        m_state    = (m_mode == 2) ? 1 : 2;
    endtask

    // One clock edge of the session rules: pop first, then store, then state transition.
    task automatic model_step();
        int s;
        bit ev, stored, full_before;
        logic [ENTRY_W-1:0] e;
        s = m_state;
        ev = wb_valid && (wb_reg != 5'd0) && MASK[wb_reg];
        stored = 1'b0;
        full_before = (mq.size() == DEPTH);
        if (rd_ready && mq.size() != 0) e = mq.pop_front();
        if ((s == 1 || s == 2) && ev && !(m_mode == 1 && full_before)) begin
            mq.push_back({wb_pc, wb_reg, wb_data});
            stored = 1'b1;
            if (mq.size() > DEPTH) begin
                e = mq.pop_front();
                if (m_mode == 0) m_ovf = 1'b1;
            end
        end
        case (s)
            0: if (arm) model_start();
            3: if (arm) begin mq.delete(); m_ovf = 1'b0; model_start(); end
            1: begin
                if (stop) m_state = 3;
                else if (stored && wb_pc == trig_pc) begin
                    m_post  = m_post_cfg;
                    m_state = (m_post_cfg == 0) ? 3 : 2;
                end
            end
            2: begin
                if (stop) m_state = 3;
                else if (stored && m_mode == 2) begin
                    m_post--;
                    if (m_post == 0) m_state = 3;
                end else if (stored && m_mode == 1 && mq.size() == DEPTH) m_state = 3;
            end
            default: m_state = 0;
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_valid"}, ENTRY_W'(rd_valid), ENTRY_W'(mq.size() != 0));
        chk({tag, "_data"},  rd_data, (mq.size() != 0) ? mq[0] : ENTRY_W'(0));
        chk({tag, "_count"}, ENTRY_W'(count), ENTRY_W'(mq.size()));
        chk({tag, "_state"}, ENTRY_W'(state), ENTRY_W'(m_state));
        chk({tag, "_ovf"},   ENTRY_W'(overflow), ENTRY_W'(m_ovf));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic wr(input int r, input int d, input int pc, input string tag);
        wb_valid = 1'b1;
        wb_reg   = REG_AW'(r);
        wb_data  = DATA_W'(d);
        wb_pc    = PC_W'(pc);
        step(tag);
        wb_valid = 1'b0;
    endtask

    task automatic start(input int md, input int tpc, input int pc_cnt, input string tag);
        arm = 1'b1; mode = 2'(md); trig_pc = PC_W'(tpc); post_cnt = CNT_W'(pc_cnt);
        step(tag);
        arm = 1'b0;
    endtask

    task automatic do_stop(input string tag);
        stop = 1'b1;
        step(tag);
        stop = 1'b0;
    endtask

    initial begin
        int pcs[6];
        pcs = '{32'h10, 32'h20, 32'h40, 32'h44, 32'h48, 32'h4C};
        reset_n = 1'b0; arm = 1'b0; mode = 2'd0; trig_pc = '0; post_cnt = '0; stop = 1'b0;
        wb_valid = 1'b0; wb_reg = '0; wb_data = '0; wb_pc = '0; rd_ready = 1'b0;
        model_reset();
        #2;
        check_all("reset");
        #10;
        reset_n = 1'b1;

        // Asynchronous reset in the middle of a capture holding five entries.
        start(0, 0, 0, "t1_arm");
        for (int i = 0; i < 5; i++) wr(1 + i, i, 32'h200 + 4 * i, "t1_wr");
        chk("t1_count5", ENTRY_W'(count), ENTRY_W'(5));
        #2;
        reset_n = 1'b0;
        #1;
        chk("t1_rst_count", ENTRY_W'(count), ENTRY_W'(0));
        chk("t1_rst_state", ENTRY_W'(state), ENTRY_W'(0));
        chk("t1_rst_valid", ENTRY_W'(rd_valid), ENTRY_W'(0));
        chk("t1_rst_data",  rd_data, ENTRY_W'(0));
        chk("t1_rst_ovf",   ENTRY_W'(overflow), ENTRY_W'(0));
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        check_all("t1_release");

        // Wrap mode, 18 writes: oldest two lost, overflow set.
        start(0, 0, 0, "t3_arm");
        for (int i = 1; i <= 18; i++) wr(1 + (i % 3), i, 32'h300 + 4 * i, "t3_wr");
        chk("t3_ovf", ENTRY_W'(overflow), ENTRY_W'(1));
        chk("t3_count", ENTRY_W'(count), ENTRY_W'(16));
        rd_ready = 1'b1;
        for (int i = 3; i <= 18; i++) begin
            chk("t3_drain", ENTRY_W'(rd_data[DATA_W-1:0]), ENTRY_W'(i));
            step("t3_pop");
        end
        rd_ready = 1'b0;
        do_stop("t3_stop");

        // Full wrap buffer with push and pop on the same edge.
        start(0, 0, 0, "t6_arm");
        chk("t6_ovf_clr", ENTRY_W'(overflow), ENTRY_W'(0));
        for (int i = 0; i < 16; i++) wr(2, 100 + i, 32'h600 + 4 * i, "t6_wr");
        chk("t6_head", ENTRY_W'(rd_data[DATA_W-1:0]), ENTRY_W'(100));
        rd_ready = 1'b1;
        wr(3, 200, 32'h700, "t6_pushpop");
        rd_ready = 1'b0;
        chk("t6_count", ENTRY_W'(count), ENTRY_W'(16));
        chk("t6_ovf", ENTRY_W'(overflow), ENTRY_W'(0));
        chk("t6_newhead", ENTRY_W'(rd_data[DATA_W-1:0]), ENTRY_W'(101));
        do_stop("t6_stop");

        // Stop-when-full: 20 writes, first 16 kept.
        start(1, 0, 0, "t2_arm");
        for (int i = 0; i < 20; i++) wr(1 + (i % 3), i, 32'h100 + 4 * i, "t2_wr");
        chk("t2_count", ENTRY_W'(count), ENTRY_W'(16));
        chk("t2_state", ENTRY_W'(state), ENTRY_W'(3));
        chk("t2_ovf", ENTRY_W'(overflow), ENTRY_W'(0));
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t2_drain", ENTRY_W'(rd_data[DATA_W-1:0]), ENTRY_W'(i));
            step("t2_pop");
        end
        rd_ready = 1'b0;

        // Trigger at 0x40 with two post-trigger events.
        start(2, 32'h40, 2, "t4_arm");
        for (int i = 0; i < 6; i++) begin
            wr(4, i, pcs[i], "t4_wr");
            if (i == 4) chk("t4_done", ENTRY_W'(state), ENTRY_W'(3));
        end
        chk("t4_count", ENTRY_W'(count), ENTRY_W'(5));
        rd_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t4_drain_pc", ENTRY_W'(rd_data[ENTRY_W-1 -: PC_W]), ENTRY_W'(pcs[i]));
            step("t4_pop");
        end
        rd_ready = 1'b0;

        // GR0 and masked-out GR15 are never recorded.
        start(0, 0, 0, "t5_arm");
        wr(0, 32'hAAAA, 32'h500, "t5_gr0");
        wr(15, 32'hBBBB, 32'h504, "t5_gr15");
        chk("t5_count", ENTRY_W'(count), ENTRY_W'(0));
        chk("t5_valid", ENTRY_W'(rd_valid), ENTRY_W'(0));

        // Randomized sessions against the model.
        for (int i = 0; i < 4000; i++) begin
            arm      = ($urandom_range(0, 15) == 0);
            mode     = 2'($urandom_range(0, 3));
            post_cnt = CNT_W'($urandom_range(0, DEPTH));
            trig_pc  = PC_W'(32'h10 + 4 * $urandom_range(0, 7));
            stop     = ($urandom_range(0, 63) == 0);
            wb_valid = 1'($urandom_range(0, 1));
            wb_reg   = REG_AW'($urandom_range(0, 31));
            wb_data  = $urandom;
            wb_pc    = PC_W'(32'h10 + 4 * $urandom_range(0, 7));
            rd_ready = ($urandom_range(0, 3) == 0);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
